systolic_tile_ctrl: RTL and testbench

SYSTOLIC_TILE_CTRL -- requirements
Module: systolic_tile_ctrl

---
 rtl/systolic_tile_ctrl.sv | 139 +++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_ctrl
// Purpose  : LOAD/MAC/OUT sequencer for a ROWSxCOLS systolic tile with skewed FIFO reads.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    x_recv_val,
  output logic                                    x_recv_rdy,
  input  logic                                    w_recv_val,
  output logic                                    w_recv_rdy,
  input  logic [ROWS-1:0]                         x_fifo_full,
  input  logic [ROWS-1:0]                         x_fifo_empty,
  output logic [ROWS-1:0]                         x_fifo_wen,
  output logic [ROWS-1:0]                         x_fifo_ren,
  input  logic [COLS-1:0]                         w_fifo_full,
  input  logic [COLS-1:0]                         w_fifo_empty,
  output logic [COLS-1:0]                         w_fifo_wen,
  output logic [COLS-1:0]                         w_fifo_ren,
  output logic                                    mac_en,
  output logic                                    acc_clr,
  output logic                                    out_val,
  input  logic                                    out_rdy,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                    underflow
);

  localparam int T  = DEPTH + ROWS + COLS - 1;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [CW-1:0] C_LAST     = CW'(T - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(ROWS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [RW-1:0] row_q, row_d;
  logic          clr_q, clr_d;
  logic          uf_q, uf_d;

  logic in_load, in_mac, in_out;
  logic x_all_full, w_all_full;

  assign in_load    = (state_q == S_LOAD);
  assign in_mac     = (state_q == S_MAC);
  assign in_out     = (state_q == S_OUT);
  assign x_all_full = &x_fifo_full;
  assign w_all_full = &w_fifo_full;

  assign x_recv_rdy = in_load & ~x_all_full;
  assign w_recv_rdy = in_load & ~w_all_full;
  assign x_fifo_wen = {ROWS{x_recv_val & x_recv_rdy}};
  assign w_fifo_wen = {COLS{w_recv_val & w_recv_rdy}};
  assign mac_en     = in_mac;
  assign out_val    = in_out;
  assign out_row    = row_q;
  assign acc_clr    = clr_q & in_load;
  assign underflow  = uf_q;

  // (cyc - lo) < DEPTH: when cyc < lo the difference wraps above DEPTH because lo+DEPTH <= T-1.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_xren
    localparam logic [CW-1:0] C_LO = CW'(gi);
    assign x_fifo_ren[gi] = in_mac && ((cyc_q - C_LO) < C_DEPTH);
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_wren
    localparam logic [CW-1:0] C_LO = CW'(gj);
    assign w_fifo_ren[gj] = in_mac && ((cyc_q - C_LO) < C_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    row_d   = row_q;
    clr_d   = 1'b0;
    uf_d    = uf_q | (|(x_fifo_ren & x_fifo_empty)) | (|(w_fifo_ren & w_fifo_empty));
    case (state_q)
      S_LOAD: begin
        cyc_d = '0;
        row_d = '0;
        if (x_all_full && w_all_full) state_d = S_MAC;
      end
      S_MAC: begin
        if (cyc_q == C_LAST) begin
          state_d = S_OUT;
          cyc_d   = '0;
          row_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_OUT: begin
        if (out_rdy) begin
          if (row_q == C_ROW_LAST) begin
            state_d = S_LOAD;
            row_d   = '0;
            clr_d   = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        cyc_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cyc_q   <= '0;
      row_q   <= '0;
      clr_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
      uf_q    <= uf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_ctrl
// Purpose  : Directed bench for systolic_tile_ctrl (ROWS=2, COLS=3, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_ctrl;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int DEPTH = 4;
  localparam int T     = DEPTH + ROWS + COLS - 1;

  logic            clk;
  logic            rst;
  logic            x_recv_val, w_recv_val, out_rdy;
  logic            x_recv_rdy, w_recv_rdy;
  logic [ROWS-1:0] x_fifo_full, x_fifo_empty, x_fifo_wen, x_fifo_ren;
  logic [COLS-1:0] w_fifo_full, w_fifo_empty, w_fifo_wen, w_fifo_ren;
  logic [COLS-1:0] w_empty_force;
  logic            mac_en, acc_clr, out_val, underflow;
  logic [0:0]      out_row;

  int checks = 0;
  int errors = 0;
  int xcnt [ROWS];
  int wcnt [COLS];

  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .x_recv_val   (x_recv_val),
    .x_recv_rdy   (x_recv_rdy),
    .w_recv_val   (w_recv_val),
    .w_recv_rdy   (w_recv_rdy),
    .x_fifo_full  (x_fifo_full),
    .x_fifo_empty (x_fifo_empty),
    .x_fifo_wen   (x_fifo_wen),
    .x_fifo_ren   (x_fifo_ren),
    .w_fifo_full  (w_fifo_full),
    .w_fifo_empty (w_fifo_empty),
    .w_fifo_wen   (w_fifo_wen),
    .w_fifo_ren   (w_fifo_ren),
    .mac_en       (mac_en),
    .acc_clr      (acc_clr),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_row      (out_row),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO occupancy model; FIFOs are flushed along with the controller reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) xcnt[i] <= 0;
      for (int j = 0; j < COLS; j++) wcnt[j] <= 0;
    end else begin
      for (int i = 0; i < ROWS; i++) xcnt[i] <= xcnt[i] + int'(x_fifo_wen[i]) - int'(x_fifo_ren[i]);
      for (int j = 0; j < COLS; j++) wcnt[j] <= wcnt[j] + int'(w_fifo_wen[j]) - int'(w_fifo_ren[j]);
    end
  end

  always_comb begin
    x_fifo_full  = '0;
    x_fifo_empty = '0;
    w_fifo_full  = '0;
    w_fifo_empty = '0;
    for (int i = 0; i < ROWS; i++) begin
      x_fifo_full[i]  = (xcnt[i] == DEPTH);
      x_fifo_empty[i] = (xcnt[i] == 0);
    end
    for (int j = 0; j < COLS; j++) begin
      w_fifo_full[j]  = (wcnt[j] == DEPTH);
      w_fifo_empty[j] = (wcnt[j] == 0) | w_empty_force[j];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Loads one tile; xpat gates x_recv_val cycle by cycle while W streams every cycle.
  task automatic load_tile(input logic [15:0] xpat);
    int  n = 0;
    bit  xf, wf;
    forever begin
      xf = (xcnt[0] == DEPTH) && (xcnt[ROWS-1] == DEPTH);
      wf = (wcnt[0] == DEPTH) && (wcnt[COLS-1] == DEPTH);
      if ((xf && wf) || n >= 40) break;
      x_recv_val = xpat[n % 16];
      w_recv_val = 1'b1;
      #1;
      check("load_mac_en", mac_en, 0);
      check("load_x_wen", x_fifo_wen, (x_recv_val && !xf) ? 32'h3 : 32'h0);
      check("load_w_wen", w_fifo_wen, !wf ? 32'h7 : 32'h0);
      if (n > 0) check("load_acc_clr", acc_clr, 0);
      tick();
      n++;
    end
    x_recv_val = 1'b0;
    w_recv_val = 1'b0;
    #1;
    check("load_timeout", n < 40, 1);
    check("full_mac_en", mac_en, 0);
    check("full_x_rdy", x_recv_rdy, 0);
    check("full_wen", {x_fifo_wen, w_fifo_wen}, 0);
    tick();
  endtask

  task automatic run_mac(input bit force_uf);
    int xs [ROWS];
    int ws [COLS];
    logic [ROWS-1:0] ex;
    logic [COLS-1:0] ew;
    for (int i = 0; i < ROWS; i++) xs[i] = 0;
    for (int j = 0; j < COLS; j++) ws[j] = 0;
    for (int c = 0; c < T; c++) begin
      if (force_uf && c == 0) w_empty_force = 3'b001;
      #1;
      for (int i = 0; i < ROWS; i++) ex[i] = (c >= i) && (c < i + DEPTH);
      for (int j = 0; j < COLS; j++) ew[j] = (c >= j) && (c < j + DEPTH);
      check("mac_en", mac_en, 1);
      check("mac_x_ren", x_fifo_ren, ex);
      check("mac_w_ren", w_fifo_ren, ew);
      check("mac_rdy", {x_recv_rdy, w_recv_rdy}, 0);
      if (force_uf && c == 1) check("uf_set", underflow, 1);
      for (int i = 0; i < ROWS; i++) xs[i] += int'(x_fifo_ren[i]);
      for (int j = 0; j < COLS; j++) ws[j] += int'(w_fifo_ren[j]);
      tick();
      w_empty_force = '0;
    end
    check("x1_reads", xs[1], DEPTH);
    check("w2_reads", ws[2], DEPTH);
    check("w0_reads", ws[0], DEPTH);
  endtask

  task automatic drain(input int holds);
    out_rdy = 1'b0;
    for (int h = 0; h < holds; h++) begin
      #1;
      check("hold_mac_en", mac_en, 0);
      check("hold_out_val", out_val, 1);
      check("hold_out_row", out_row, 0);
      tick();
    end
    out_rdy = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      #1;
      check("out_val", out_val, 1);
      check("out_row", out_row, r);
      tick();
    end
    out_rdy = 1'b0;
    #1;
    check("clr_pulse", acc_clr, 1);
    check("clr_out_val", out_val, 0);
    check("clr_x_rdy", x_recv_rdy, 1);
  endtask

  initial begin
    rst = 1'b1;
    x_recv_val = 1'b0;
    w_recv_val = 1'b0;
    out_rdy = 1'b0;
    w_empty_force = '0;
    #3;
    check("rst_rdy", {x_recv_rdy, w_recv_rdy}, 2'b11);
    check("rst_ctl", {mac_en, acc_clr, out_val, underflow}, 0);
    check("rst_row", out_row, 0);
    check("rst_en", {x_fifo_ren, w_fifo_ren, x_fifo_wen, w_fifo_wen}, 0);
    @(posedge clk);
    tick();
    rst = 1'b0;

    // Tile 1: continuous load, stalled drain
    load_tile(16'hFFFF);
    run_mac(1'b0);
    drain(3);
    check("t1_uf", underflow, 0);

    // Tile 2: back-to-back, X stream with gaps
    load_tile(16'b1011_0010_0110_1000);
    run_mac(1'b0);
    drain(0);

    // Tile 3: read of an empty W FIFO at cyc 0
    load_tile(16'hFFFF);
    run_mac(1'b1);
    check("uf_in_out", underflow, 1);
    drain(1);
    check("uf_in_load", underflow, 1);

    // Tile 4: asynchronous reset at cyc 5
    load_tile(16'hFFFF);
    check("uf_next_tile", underflow, 1);
    for (int c = 0; c < 5; c++) tick();
    #1;
    check("pre_rst_mac_en", mac_en, 1);
    rst = 1'b1;
    #1;
    check("arst_ctl", {mac_en, acc_clr, out_val, underflow}, 0);
    check("arst_ren", {x_fifo_ren, w_fifo_ren}, 0);
    check("arst_rdy", {x_recv_rdy, w_recv_rdy}, 2'b11);
    #1;
    rst = 1'b0;
    tick();
    #1;
    check("post_rst_clr", acc_clr, 0);
    check("post_rst_out_val", out_val, 0);

    // Tile 5: normal completion after reset
    load_tile(16'hFFFF);
    run_mac(1'b0);
    drain(0);
    check("t5_uf", underflow, 0);
    tick();
    check("clr_one_cycle", acc_clr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
